// File: rtl/cla5_stim_checker_if.sv
// Datapath bus between the stimulus checker and the registered CLA under test.
// The checker drives the operands and receives the registered result.
interface cla5_stim_checker_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output a,
    output b,
    output cin,
    input  sum,
    input  cout
  );

  modport slave (
    input  a,
    input  b,
    input  cin,
    output sum,
    output cout
  );
endinterface

// File: rtl/cla5_stim_checker.sv
// Exhaustive stimulus driver and response checker for a registered WIDTH-bit adder.
// Sweeps every {cin,b,a} once, compares delayed expected results, reports errors.
module cla5_stim_checker #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ERR_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  cla5_stim_checker_if.master  dp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int unsigned VW = 2 * WIDTH + 1;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned EW = 1 + VW + RW;
  localparam int unsigned CW = $clog2(LATENCY + 2);
  localparam logic [VW-1:0] VecMax = {VW{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [VW-1:0]    drv_q, drv_d;
  logic             drv_vld_q, drv_vld_d;
  logic [CW-1:0]    drain_q, drain_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VW-1:0]    ff_q, ff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  // Entry layout: {valid, vector index, expected {cout,sum}}
  logic [EW-1:0]    line_q [LATENCY];
  logic [EW-1:0]    line_d [LATENCY];

  logic [RW-1:0]    drv_exp;
  logic [EW-1:0]    tail;
  logic             mismatch;

  // Expected value is formed from the registered drive so the line stays
  // aligned with what the datapath actually sampled.
  assign drv_exp = RW'(drv_q[WIDTH-1:0]) + RW'(drv_q[2*WIDTH-1:WIDTH]) + RW'(drv_q[VW-1]);
  assign tail     = line_q[LATENCY-1];
  assign mismatch = tail[EW-1] && ({dp.cout, dp.sum} != tail[RW-1:0]);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    drv_d     = '0;
    drv_vld_d = 1'b0;
    drain_d   = drain_q;
    err_d     = err_q;
    ff_d      = ff_q;

    line_d[0] = {drv_vld_q, drv_q, drv_exp};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      line_d[i] = line_q[i-1];
    end

    if (mismatch) begin
      if (err_q != {ERR_W{1'b1}}) begin
        err_d = err_q + 1'b1;
      end
      if (err_q == '0) begin
        ff_d = tail[RW +: VW];
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          vec_d     = VW'(1);
          drv_d     = '0;
          drv_vld_d = 1'b1;
          err_d     = '0;
          ff_d      = '0;
          for (int unsigned i = 0; i < LATENCY; i++) begin
            line_d[i] = '0;
          end
        end
      end
      StRun: begin
        drv_d     = vec_q;
        drv_vld_d = 1'b1;
        if (vec_q == VecMax) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      StDrain: begin
        // One extra cycle covers the output register in front of the line.
        if (drain_q == CW'(LATENCY)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      drv_q     <= '0;
      drv_vld_q <= 1'b0;
      drain_q   <= '0;
      err_q     <= '0;
      ff_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      drv_q     <= drv_d;
      drv_vld_q <= drv_vld_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      ff_q      <= ff_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        line_q[i] <= line_d[i];
      end
    end
  end

  assign dp.a       = drv_q[WIDTH-1:0];
  assign dp.b       = drv_q[2*WIDTH-1:WIDTH];
  assign dp.cin     = drv_q[VW-1];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_cla5_stim_checker.sv
// Bench for cla5_stim_checker: behavioural registered adders with injectable faults,
// scoreboard of expected run results popped when each run reports done.
module tb_cla5_stim_checker;

  localparam int NV = 2048;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_aux;
  logic [1:0] mode;  // 0 golden, 1 sum[0] stuck-at-0, 2 three registers

  always #5 clk = ~clk;

  cla5_stim_checker_if #(.WIDTH(5)) dp_if ();
  cla5_stim_checker_if #(.WIDTH(5)) dp3_if ();
  cla5_stim_checker_if #(.WIDTH(5)) dps_if ();

  logic        busy, done, pass;
  logic [15:0] err;
  logic [10:0] ff;
  logic        busy3, done3, pass3;
  logic [15:0] err3;
  logic [10:0] ff3;
  logic        busy_s, done_s, pass_s;
  logic [3:0]  err_s;
  logic [10:0] ff_s;

  cla5_stim_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .dp(dp_if),
    .busy(busy), .done(done), .pass(pass), .err_count(err), .first_fail(ff)
  );

  cla5_stim_checker #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start_aux), .dp(dp3_if),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_fail(ff3)
  );

  cla5_stim_checker #(.ERR_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start_aux), .dp(dps_if),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .first_fail(ff_s)
  );

  function automatic logic [5:0] add_of(input logic [10:0] v);
    return {1'b0, v[4:0]} + {1'b0, v[9:5]} + {5'b0, v[10]};
  endfunction

  // Behavioural datapaths: input register, adder, output register (+ optional extra stage)
  logic [10:0] in_q, in3_q, ins_q;
  logic [5:0]  o1_q, o2_q, p1_q, p2_q, s1_q;
  always_ff @(posedge clk) begin
    in_q  <= {dp_if.cin, dp_if.b, dp_if.a};
    o1_q  <= add_of(in_q);
    o2_q  <= o1_q;
    in3_q <= {dp3_if.cin, dp3_if.b, dp3_if.a};
    p1_q  <= add_of(in3_q);
    p2_q  <= p1_q;
    ins_q <= {dps_if.cin, dps_if.b, dps_if.a};
    s1_q  <= add_of(ins_q);
  end

  assign {dp_if.cout, dp_if.sum} = (mode == 2'd2) ? o2_q :
                                   (mode == 2'd1) ? (o1_q & 6'h3E) : o1_q;
  assign {dp3_if.cout, dp3_if.sum} = p2_q;
  assign {dps_if.cout, dps_if.sum} = s1_q ^ 6'h1F;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int len;
    bit pass;
    int err;
    int ff;
    bit nz_only;
  } exp_t;

  exp_t sb_q[$];

  task automatic run_main(input int e_len, input bit e_pass, input int e_err, input int e_ff,
                          input bit nz_only, input int poke1, input int poke2);
    exp_t e;
    int   cnt;
    int   g;
    e = '{len: e_len, pass: e_pass, err: e_err, ff: e_ff, nz_only: nz_only};
    sb_q.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("run_busy_first", busy, 1);
    check("run_err_clear", err, 0);
    check("run_done_low", done, 0);
    cnt = 0;
    g   = 0;
    while (!done && g < 3000) begin
      g++;
      if (busy) cnt++;
      check("drive_vec", {dp_if.cin, dp_if.b, dp_if.a}, (cnt <= NV) ? cnt - 1 : 0);
      start = (cnt == poke1) || (cnt == poke2);
      @(negedge clk);
    end
    start = 1'b0;
    check("run_finished", done, 1);
    e = sb_q.pop_front();
    check("run_len", cnt, e.len);
    check("run_pass", pass, e.pass);
    if (e.nz_only) begin
      check("run_err_nonzero", err != 0, 1);
    end else begin
      check("run_err", err, e.err);
      check("run_first_fail", ff, e.ff);
    end
    repeat (3) @(negedge clk);
    check("done_hold", done, 1);
    check("busy_hold_low", busy, 0);
  endtask

  initial begin
    int g;
    int cnt3;
    int cnt_s;
    rst       = 1'b1;
    start     = 1'b0;
    start_aux = 1'b0;
    mode      = 2'd0;
    repeat (3) @(negedge clk);
    // start coincident with reset must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err, 0);
    check("rst_ff", ff, 0);
    check("rst_drive", {dp_if.cin, dp_if.b, dp_if.a}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("aux_idle_done", {done3, done_s}, 0);

    // Golden run with start pokes in RUN and in DRAIN
    mode = 2'd0;
    run_main(NV + 2, 1'b1, 0, 0, 1'b0, 100, NV + 1);

    // sum[0] stuck-at-0: every odd result mismatches, first at index 1
    mode = 2'd1;
    run_main(NV + 2, 1'b0, 1024, 1, 1'b0, -1, -1);

    // Start from DONE with a clean datapath: counters clear, run passes
    mode = 2'd0;
    run_main(NV + 2, 1'b1, 0, 0, 1'b0, -1, -1);

    // Three registers against LATENCY=2
    mode = 2'd2;
    run_main(NV + 2, 1'b0, 0, 0, 1'b1, -1, -1);

    // Reset in the middle of a failing run
    mode = 2'd1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    g = 1;
    while (g < 500) begin
      @(negedge clk);
      g++;
    end
    check("pre_rst_err_nonzero", err != 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_drive", {dp_if.cin, dp_if.b, dp_if.a}, 0);
    repeat (5) @(negedge clk);
    check("post_rst_err", err, 0);
    check("post_rst_busy", busy, 0);
    mode = 2'd0;
    run_main(NV + 2, 1'b1, 0, 0, 1'b0, -1, -1);

    // LATENCY=3 with a three-register adder, and ERR_W=4 saturation
    @(negedge clk) start_aux = 1'b1;
    @(negedge clk) start_aux = 1'b0;
    cnt3  = 0;
    cnt_s = 0;
    g     = 0;
    while (!(done3 && done_s) && g < 3000) begin
      g++;
      if (busy3) cnt3++;
      if (busy_s) cnt_s++;
      @(negedge clk);
    end
    check("l3_finished", done3, 1);
    check("l3_len", cnt3, NV + 3);
    check("l3_pass", pass3, 1);
    check("l3_err", err3, 0);
    check("sat_finished", done_s, 1);
    check("sat_len", cnt_s, NV + 2);
    check("sat_pass", pass_s, 0);
    check("sat_err", err_s, 15);
    check("sat_first_fail", ff_s, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
